i2c_bit_engine: RTL

// - Byte-level I2C master that consumes the clock_divider output (clk_div) as its timing reference.
// - Generates START, STOP, 8-bit WRITE with ACK check, and 8-bit READ with ACK/NACK drive.
// - Drives SCL/SDA as open-drain enables for the MPU-6050 bus.
// - Sits between the divider and the register-transaction sequencer.

---
 rtl/i2c_bit_engine_if.sv | 26 ++
 rtl/i2c_bit_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_engine_if.sv
// Command handshake, result and open-drain pad signals between the sequencer and the I2C bit engine.
// The master modport is the sequencer/pad side; the slave modport is the engine itself.
interface i2c_bit_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       nack_tx;
    logic [7:0] rx_data;
    logic       ack_err;
    logic       done;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;

    modport master (
        output cmd_valid, cmd, tx_data, nack_tx, sda_in,
        input  cmd_ready, rx_data, ack_err, done, busy, scl_oe, sda_oe
    );

    modport slave (
        input  cmd_valid, cmd, tx_data, nack_tx, sda_in,
        output cmd_ready, rx_data, ack_err, done, busy, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_bit_engine.sv
// Byte-level I2C master: START/STOP take 4 phases, WRITE/READ 36 phases, each phase PHASE_TICKS clk_div ticks.
// One command in flight: cmd_ready drops the cycle after accept and returns with the one-cycle done pulse.
module i2c_bit_engine #(
    parameter int PHASE_TICKS = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            clk_div,
    i2c_bit_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, STOP, DATA, ACK, ERR} state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [7:0] TICK_LAST = 8'(PHASE_TICKS - 1);

    logic [SYNC_STAGES-1:0] div_sync_q, sda_sync_q;
    logic                   div_prev_q;
    logic                   tick, sda_s, ready, accept;

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rd_q, rd_d, nack_q, nack_d, owned_q, owned_d;
    logic       scl_q, scl_d, sda_q, sda_d, done_q, done_d, ack_err_q, ack_err_d;

    assign tick   = div_sync_q[SYNC_STAGES-1] & ~div_prev_q;
    assign sda_s  = sda_sync_q[SYNC_STAGES-1];
    assign ready  = (state_q == IDLE) || (state_q == ERR);
    assign accept = bus.cmd_valid && ready;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_sync_q <= '0;
            sda_sync_q <= '1;
            div_prev_q <= 1'b0;
        end else begin
            div_sync_q <= {div_sync_q[SYNC_STAGES-2:0], clk_div};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            div_prev_q <= div_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        tcnt_d    = tcnt_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        rd_d      = rd_q;
        nack_d    = nack_q;
        owned_d   = owned_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        if (accept) begin
            phase_d   = 2'd0;
            tcnt_d    = 8'd0;
            bit_d     = 3'd7;
            tx_d      = bus.tx_data;
            rd_d      = bus.cmd[0];
            nack_d    = bus.nack_tx;
            ack_err_d = 1'b0;
            if (bus.cmd == CMD_START) begin
                state_d = START;
                sda_d   = 1'b0;
            end else if (!owned_q) begin
                // Illegal without bus ownership: complete at once, touch nothing on the bus.
                state_d   = ERR;
                done_d    = 1'b1;
                ack_err_d = 1'b1;
            end else if (bus.cmd == CMD_STOP) begin
                state_d = STOP;
                sda_d   = 1'b1;
            end else begin
                state_d = DATA;
                sda_d   = bus.cmd[0] ? 1'b0 : ~bus.tx_data[7];
            end
        end else if (state_q == ERR) begin
            state_d = IDLE;
        end else if (tick && state_q != IDLE) begin
            if (tcnt_q != TICK_LAST) begin
                tcnt_d = tcnt_q + 8'd1;
            end else begin
                tcnt_d  = 8'd0;
                phase_d = phase_q + 2'd1;
                unique case (phase_q)
                    2'd0: scl_d = 1'b0;
                    2'd1: begin
                        if (state_q == START) sda_d = 1'b1;
                        if (state_q == STOP)  sda_d = 1'b0;
                    end
                    2'd2: begin
                        if (state_q != STOP) scl_d = 1'b1;
                        if (state_q == DATA && rd_q)  rx_sh_d   = {rx_sh_q[6:0], sda_s};
                        if (state_q == ACK  && !rd_q) ack_err_d = sda_s;
                    end
                    default: begin
                        if (state_q == DATA && bit_q != 3'd0) begin
                            bit_d = bit_q - 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                            sda_d = rd_q ? 1'b0 : ~tx_q[6];
                        end else if (state_q == DATA) begin
                            state_d = ACK;
                            sda_d   = rd_q ? ~nack_q : 1'b0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            if (state_q == START) owned_d = 1'b1;
                            if (state_q == STOP)  owned_d = 1'b0;
                            if (state_q == ACK && rd_q) rx_data_d = rx_sh_q;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= 2'd0;
            bit_q     <= 3'd7;
            tcnt_q    <= 8'd0;
            tx_q      <= 8'h00;
            rx_sh_q   <= 8'h00;
            rx_data_q <= 8'h00;
            rd_q      <= 1'b0;
            nack_q    <= 1'b0;
            owned_q   <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            tcnt_q    <= tcnt_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
            owned_q   <= owned_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.busy      = ~ready;
    assign bus.done      = done_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.scl_oe    = scl_q;
    assign bus.sda_oe    = sda_q;
endmodule
